// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage pipeline: keeps a shadow of the E/M/W slots and derives
// the D-stage stall plus every bypass select from that registered state.
module hazard_scoreboard #(
    parameter int NUM_SRC      = 2,
    parameter int TW           = 2,
    parameter int MULT_CYCLES  = 5,
    parameter int DIV_CYCLES   = 10,
    parameter int LATE_REG_MAX = 31
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    d_valid,
    input  logic [NUM_SRC*5-1:0]    d_src,
    input  logic [NUM_SRC-1:0]      d_use,
    input  logic [NUM_SRC*TW-1:0]   d_tuse,
    input  logic [4:0]              d_dst,
    input  logic [TW-1:0]           d_tnew,
    input  logic                    d_late,
    input  logic                    d_md_start,
    input  logic                    d_md_div,
    input  logic                    d_md_use,
    input  logic [4:0]              m_late_dst,
    output logic                    stall,
    output logic [NUM_SRC*2-1:0]    fwd_d,
    output logic [NUM_SRC*2-1:0]    fwd_e,
    output logic                    fwd_m,
    output logic                    md_start,
    output logic                    md_busy
);
    localparam int MdMax = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CW = $clog2(MdMax + 1);
    localparam logic [5:0] LateMax = 6'(LATE_REG_MAX);
    // Store data travels as source 1; a single-source build has no store bypass.
    localparam int StIdx = (NUM_SRC > 1) ? 1 : 0;
    localparam logic HasStore = (NUM_SRC > 1);

    logic                        eVldReg, eLateReg, eMdReg, eMdDivReg;
    logic [4:0]                  eDstReg;
    logic [TW-1:0]               eTnewReg;
    logic [NUM_SRC-1:0][4:0]     eSrcReg;
    logic [NUM_SRC-1:0]          eUseReg;
    logic                        mVldReg, mLateReg, mUse1Reg;
    logic [4:0]                  mDstReg, mSrc1Reg;
    logic [TW-1:0]               mTnewReg;
    logic                        wVldReg;
    logic [4:0]                  wDstReg;
    logic [CW-1:0]               mdCountReg;

    logic [NUM_SRC-1:0]          srcHazard;
    logic                        mdStall;
    logic                        takeD;

    // A late slot's destination is unknown, so it conservatively claims every real register.
    function automatic logic slotMatch(input logic vld, input logic late,
                                       input logic [4:0] dst, input logic [4:0] r);
        return vld && (r != 5'd0) && (late ? ({1'b0, r} <= LateMax) : (dst == r));
    endfunction

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : gSrc
        logic [4:0]    dSrc;
        logic [TW-1:0] tuse;
        logic          hitE, hitM, hitW, eHitM, eHitW;
        logic [1:0]    fwdDSel, fwdESel;

        assign dSrc  = d_src[gi*5 +: 5];
        assign tuse  = d_tuse[gi*TW +: TW];
        assign hitE  = slotMatch(eVldReg, eLateReg, eDstReg, dSrc);
        assign hitM  = slotMatch(mVldReg, mLateReg, mDstReg, dSrc);
        assign hitW  = slotMatch(wVldReg, 1'b0, wDstReg, dSrc);
        assign eHitM = slotMatch(mVldReg, mLateReg, mDstReg, eSrcReg[gi]);
        assign eHitW = slotMatch(wVldReg, 1'b0, wDstReg, eSrcReg[gi]);

        assign srcHazard[gi] = d_valid && d_use[gi] &&
                               ((hitE && (eLateReg || (tuse < eTnewReg))) ||
                                (hitM && (mLateReg || (tuse < mTnewReg))));

        always_comb begin
            fwdDSel = 2'b00;
            if (d_use[gi]) begin
                if (hitE && !eLateReg && (eTnewReg == '0))
                    fwdDSel = 2'b11;
                else if (hitM && !mLateReg && (mTnewReg == '0))
                    fwdDSel = 2'b01;
                else if (hitW)
                    fwdDSel = 2'b10;
            end
        end

        always_comb begin
            fwdESel = 2'b00;
            if (eVldReg && eUseReg[gi]) begin
                if (eHitM && !mLateReg && (mTnewReg == '0))
                    fwdESel = 2'b01;
                else if (eHitW)
                    fwdESel = 2'b10;
            end
        end

        assign fwd_d[gi*2 +: 2] = fwdDSel;
        assign fwd_e[gi*2 +: 2] = fwdESel;
    end

    assign md_start = eVldReg && eMdReg;
    assign md_busy  = (mdCountReg != '0);
    assign mdStall  = d_valid && d_md_use && (md_start || md_busy);
    assign stall    = (|srcHazard) || mdStall;
    assign takeD    = d_valid && !stall;
    assign fwd_m    = HasStore && mVldReg && mUse1Reg &&
                      slotMatch(wVldReg, 1'b0, wDstReg, mSrc1Reg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eVldReg    <= 1'b0;
            eLateReg   <= 1'b0;
            eMdReg     <= 1'b0;
            eMdDivReg  <= 1'b0;
            eDstReg    <= '0;
            eTnewReg   <= '0;
            eSrcReg    <= '0;
            eUseReg    <= '0;
            mVldReg    <= 1'b0;
            mLateReg   <= 1'b0;
            mUse1Reg   <= 1'b0;
            mDstReg    <= '0;
            mSrc1Reg   <= '0;
            mTnewReg   <= '0;
            wVldReg    <= 1'b0;
            wDstReg    <= '0;
            mdCountReg <= '0;
        end else begin
            // A stalled D slot leaves a bubble in E while F/D hold the instruction.
            eVldReg   <= takeD;
            eLateReg  <= d_late;
            eMdReg    <= takeD && d_md_start;
            eMdDivReg <= d_md_div;
            eDstReg   <= d_dst;
            eTnewReg  <= d_tnew;
            eSrcReg   <= d_src;
            eUseReg   <= takeD ? d_use : '0;

            mVldReg   <= eVldReg;
            mLateReg  <= eLateReg;
            mUse1Reg  <= eUseReg[StIdx];
            mDstReg   <= eDstReg;
            mSrc1Reg  <= eSrcReg[StIdx];
            mTnewReg  <= (eTnewReg == '0) ? '0 : eTnewReg - TW'(1);

            // The late destination resolves as the instruction leaves M.
            wVldReg   <= mVldReg;
            wDstReg   <= mLateReg ? m_late_dst : mDstReg;

            if (md_start)
                mdCountReg <= eMdDivReg ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            else if (mdCountReg != '0)
                mdCountReg <= mdCountReg - CW'(1);
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios plus random traffic, all
// compared against an in-flight instruction list that ages one stage per clock.
module tb_hazard_scoreboard;
    localparam int NUM_SRC = 2, TW = 2, MULT_CYCLES = 5, DIV_CYCLES = 10, LATE_REG_MAX = 31;

    logic clk = 1'b0;
    logic reset;
    logic d_valid;
    logic [NUM_SRC*5-1:0] d_src;
    logic [NUM_SRC-1:0] d_use;
    logic [NUM_SRC*TW-1:0] d_tuse;
    logic [4:0] d_dst;
    logic [TW-1:0] d_tnew;
    logic d_late, d_md_start, d_md_div, d_md_use;
    logic [4:0] m_late_dst;
    logic stall, fwd_m, md_start, md_busy;
    logic [NUM_SRC*2-1:0] fwd_d, fwd_e;

    hazard_scoreboard #(
        .NUM_SRC(NUM_SRC), .TW(TW), .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES(DIV_CYCLES), .LATE_REG_MAX(LATE_REG_MAX)
    ) dut (
        .clk(clk), .reset(reset), .d_valid(d_valid), .d_src(d_src), .d_use(d_use),
        .d_tuse(d_tuse), .d_dst(d_dst), .d_tnew(d_tnew), .d_late(d_late),
        .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
        .m_late_dst(m_late_dst), .stall(stall), .fwd_d(fwd_d), .fwd_e(fwd_e),
        .fwd_m(fwd_m), .md_start(md_start), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    // age: 0 = in E, 1 = in M, 2 = in W
    typedef struct packed {
        logic [4:0] dst;
        int         tnew;
        bit         late;
        logic [4:0] src0;
        logic [4:0] src1;
        bit         use0;
        bit         use1;
        bit         md;
        bit         div;
        int         age;
    } instr_t;

    instr_t pipe[$];
    int cyc = 0;
    int busyUntil = -1;
    int nChecks = 0;
    int nPass = 0;
    int busyCnt = 0;
    logic sStall;
    logic [3:0] sFwdD, sFwdE;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int findAge(int a);
        foreach (pipe[k]) if (pipe[k].age == a) return k;
        return -1;
    endfunction

    function automatic bit unresolved(int k);
        return pipe[k].late && pipe[k].age < 2;
    endfunction

    function automatic bit hits(int k, logic [4:0] r);
        if (k < 0 || r == 5'd0) return 1'b0;
        if (unresolved(k)) return int'(r) <= LATE_REG_MAX;
        return pipe[k].dst == r;
    endfunction

    function automatic int remain(int k);
        int t;
        if (pipe[k].age >= 2) return 0;
        t = pipe[k].tnew - pipe[k].age;
        return (t > 0) ? t : 0;
    endfunction

    function automatic bit ready(int k);
        return !unresolved(k) && remain(k) == 0;
    endfunction

    task automatic modelOutputs(output bit xs, output logic [3:0] xd, output logic [3:0] xe,
                                output bit xm, output bit xms, output bit xmb);
        int ks[3];
        logic [1:0] codeD[3];
        logic [1:0] codeE[3];
        ks[0] = findAge(0); ks[1] = findAge(1); ks[2] = findAge(2);
        codeD[0] = 2'b11; codeD[1] = 2'b01; codeD[2] = 2'b10;
        codeE[0] = 2'b00; codeE[1] = 2'b01; codeE[2] = 2'b10;
        xs = 0; xd = '0; xe = '0; xm = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            logic [4:0] r;
            int tu;
            r = d_src[i*5 +: 5];
            tu = int'(d_tuse[i*TW +: TW]);
            if (d_valid && d_use[i])
                for (int s = 0; s < 2; s++)
                    if (hits(ks[s], r) && (pipe[ks[s]].late || tu < remain(ks[s]))) xs = 1;
            if (d_use[i])
                for (int s = 0; s < 3; s++)
                    if (hits(ks[s], r) && ready(ks[s])) begin
                        xd[i*2 +: 2] = codeD[s];
                        break;
                    end
            if (ks[0] >= 0 && ((i == 0) ? pipe[ks[0]].use0 : pipe[ks[0]].use1)) begin
                r = (i == 0) ? pipe[ks[0]].src0 : pipe[ks[0]].src1;
                for (int s = 1; s < 3; s++)
                    if (hits(ks[s], r) && ready(ks[s])) begin
                        xe[i*2 +: 2] = codeE[s];
                        break;
                    end
            end
        end
        if (ks[1] >= 0 && pipe[ks[1]].use1) xm = hits(ks[2], pipe[ks[1]].src1);
        xms = (ks[0] >= 0) && pipe[ks[0]].md;
        xmb = cyc <= busyUntil;
        if (d_valid && d_md_use && (xms || xmb)) xs = 1;
    endtask

    task automatic modelEdge(bit xs);
        instr_t n;
        foreach (pipe[k]) begin
            if (pipe[k].age == 0 && pipe[k].md)
                busyUntil = cyc + (pipe[k].div ? DIV_CYCLES : MULT_CYCLES);
            if (pipe[k].age == 1 && pipe[k].late) begin
                pipe[k].dst = m_late_dst;
                pipe[k].late = 0;
            end
            pipe[k].age = pipe[k].age + 1;
        end
        for (int k = pipe.size() - 1; k >= 0; k--) if (pipe[k].age > 2) pipe.delete(k);
        if (d_valid && !xs) begin
            n.dst = d_dst; n.tnew = int'(d_tnew); n.late = d_late;
            n.src0 = d_src[4:0]; n.src1 = d_src[9:5];
            n.use0 = d_use[0]; n.use1 = d_use[1];
            n.md = d_md_start; n.div = d_md_div; n.age = 0;
            pipe.push_back(n);
        end
        cyc++;
    endtask

    task automatic modelReset();
        pipe.delete();
        busyUntil = -1;
    endtask

    task automatic step(string tag, output bit xsOut);
        bit xs, xm, xms, xmb;
        logic [3:0] xd, xe;
        #1;
        modelOutputs(xs, xd, xe, xm, xms, xmb);
        sStall = stall; sFwdD = fwd_d; sFwdE = fwd_e;
        if (md_busy) busyCnt++;
        chk({tag, " stall"}, 32'(stall), 32'(xs));
        chk({tag, " fwd_d"}, 32'(fwd_d), 32'(xd));
        chk({tag, " fwd_e"}, 32'(fwd_e), 32'(xe));
        chk({tag, " fwd_m"}, 32'(fwd_m), 32'(xm));
        chk({tag, " md_start"}, 32'(md_start), 32'(xms));
        chk({tag, " md_busy"}, 32'(md_busy), 32'(xmb));
        $display("[%0d] %s valid=%b src=%h stall=%b fwd_d=%b fwd_e=%b fwd_m=%b md_start=%b md_busy=%b",
                 cyc, tag, d_valid, d_src, stall, fwd_d, fwd_e, fwd_m, md_start, md_busy);
        @(posedge clk);
        modelEdge(xs);
        @(negedge clk);
        xsOut = xs;
    endtask

    task automatic setD(bit v, int s0, int s1, bit u0, bit u1, int t0, int t1,
                        int dst, int tnew, bit late, bit mds, bit mdd, bit mdu);
        d_valid = v; d_src = {5'(s1), 5'(s0)}; d_use = {u1, u0};
        d_tuse = {TW'(t1), TW'(t0)}; d_dst = 5'(dst); d_tnew = TW'(tnew);
        d_late = late; d_md_start = mds; d_md_div = mdd; d_md_use = mdu;
    endtask

    task automatic idle(int n);
        bit st;
        setD(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) step("idle", st);
    endtask

    // Holds the current D instruction until it enters E; returns DUT stall cycles seen.
    task automatic issue(string tag, output int stalls);
        bit st, done;
        stalls = 0;
        done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            step(tag, st);
            stalls += int'(sStall);
            done = !st;
        end
        nChecks++;
        assert (done) nPass++;
        else $error("FAIL %s bound: observed still-stalled expected issue within 40 cycles", tag);
    endtask

    initial begin
        int stalls;
        bit st;
        reset = 1'b1;
        m_late_dst = 5'd0;
        setD(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst fwd_d", 32'(fwd_d), 32'd0);
        chk("rst fwd_e", 32'(fwd_e), 32'd0);
        chk("rst fwd_m", 32'(fwd_m), 32'd0);
        chk("rst md_start", 32'(md_start), 32'd0);
        chk("rst md_busy", 32'(md_busy), 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        modelReset();
        idle(2);

        // lw $8 (tnew 2) -> addu reads $8 at tuse 1
        setD(1, 0, 0, 0, 0, 0, 0, 8, 2, 0, 0, 0, 0);  issue("lw", stalls);
        setD(1, 8, 0, 1, 0, 1, 0, 10, 1, 0, 0, 0, 0); issue("addu", stalls);
        chk("lw-addu stall cycles", 32'(stalls), 32'd1);
        idle(1);
        chk("lw-addu fwd_e", 32'(sFwdE[1:0]), 32'(2'b10));
        idle(3);

        // addu $9 (tnew 1) -> beq reads $9 in D
        setD(1, 0, 0, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0);  issue("addu9", stalls);
        setD(1, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);  issue("beq", stalls);
        chk("addu-beq stall cycles", 32'(stalls), 32'd1);
        chk("addu-beq fwd_d", 32'(sFwdD[1:0]), 32'(2'b01));
        idle(3);

        // mult -> mflo, then div -> mflo
        busyCnt = 0;
        setD(1, 4, 5, 1, 1, 1, 1, 0, 0, 0, 1, 0, 1); issue("mult", stalls);
        setD(1, 0, 0, 0, 0, 0, 0, 11, 1, 0, 0, 0, 1); issue("mflo", stalls);
        chk("mult stall cycles", 32'(stalls), 32'd6);
        idle(2);
        chk("mult busy cycles", 32'(busyCnt), 32'd5);
        busyCnt = 0;
        setD(1, 4, 5, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1); issue("div", stalls);
        setD(1, 0, 0, 0, 0, 0, 0, 11, 1, 0, 0, 0, 1); issue("mflo", stalls);
        chk("div stall cycles", 32'(stalls), 32'd11);
        idle(2);
        chk("div busy cycles", 32'(busyCnt), 32'd10);

        // $0 never creates a dependence
        setD(1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0); issue("prod0", stalls);
        setD(1, 0, 0, 1, 1, 0, 0, 3, 1, 0, 0, 0, 0); issue("cons0", stalls);
        chk("zero stall cycles", 32'(stalls), 32'd0);
        chk("zero fwd_d", 32'(sFwdD), 32'd0);
        idle(1);
        chk("zero fwd_e", 32'(sFwdE), 32'd0);
        idle(2);

        // late destination resolves to $12 at M exit
        m_late_dst = 5'd12;
        setD(1, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0);  issue("late", stalls);
        setD(1, 12, 0, 1, 0, 2, 0, 6, 1, 0, 0, 0, 0); issue("latecons", stalls);
        chk("late stall cycles", 32'(stalls), 32'd2);
        chk("late fwd_d", 32'(sFwdD[1:0]), 32'(2'b10));
        m_late_dst = 5'd0;
        idle(3);

        // reset on the third busy cycle of a div
        setD(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);  issue("div2", stalls);
        setD(1, 8, 0, 1, 0, 0, 0, 11, 1, 0, 0, 0, 1);
        repeat (3) step("mflo2", st);
        #2 reset = 1'b1;
        #1;
        chk("midrst md_busy", 32'(md_busy), 32'd0);
        chk("midrst stall", 32'(stall), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        setD(1, 8, 9, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("postrst", st);
        chk("postrst fwd_d", 32'(sFwdD), 32'd0);
        chk("postrst stall", 32'(sStall), 32'd0);
        idle(2);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            bit v, mds, mdu;
            v = ($urandom_range(0, 3) != 0);
            mds = v && ($urandom_range(0, 11) == 0);
            mdu = v && (mds || ($urandom_range(0, 7) == 0));
            setD(v, $urandom_range(0, 10), $urandom_range(0, 10),
                 v && ($urandom_range(0, 2) != 0), v && ($urandom_range(0, 2) != 0),
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 10), $urandom_range(0, 3),
                 v && ($urandom_range(0, 9) == 0), mds, $urandom_range(0, 1), mdu);
            m_late_dst = 5'($urandom_range(0, 10));
            step("rand", st);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
